centroid_accumulator: RTL and testbench

- Accumulation stage that feeds the per-coordinate divider of the k-means centroid update.
- Receives classified points: a packed 7-coordinate vector plus the index of its assigned centroid.
- Keeps one signed running sum per coordinate and one point counter for each of the centroid_num centroids.
- On flush, presents each centroid's packed accumulator and counter in turn over a valid/ready handshake, then clears that entry for the next iteration.

---
 rtl/kmeans_pkg.sv | 21 ++
 rtl/acc_lane_adder.sv | 34 +++
 rtl/centroid_accumulator.sv | 163 ++++++++++++++++
 tb/tb_centroid_accumulator.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_pkg.sv
// Shared widths, lane-vector types and FSM states for the k-means centroid accumulator.
package kmeans_pkg;

    localparam int unsigned NUM_CORDS  = 7;
    localparam int unsigned CORD_W     = 13;
    localparam int unsigned ACC_CORD_W = 22;
    localparam int unsigned CNT_W      = 10;
    localparam int unsigned NUM_CENT   = 8;
    localparam int unsigned IDX_W      = $clog2(NUM_CENT);
    localparam int unsigned DATA_W     = NUM_CORDS * CORD_W;
    localparam int unsigned ACC_W      = NUM_CORDS * ACC_CORD_W;

    typedef logic [NUM_CORDS-1:0][CORD_W-1:0]     cord_vec_t;
    typedef logic [NUM_CORDS-1:0][ACC_CORD_W-1:0] acc_vec_t;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/acc_lane_adder.sv
// Seven-lane signed adder: sign-extends each coordinate onto its accumulator lane and
// flags lanes whose two's-complement sum wrapped.
module acc_lane_adder
    import kmeans_pkg::*;
(
    input  logic [ACC_W-1:0]     acc,
    input  logic [DATA_W-1:0]    point,
    output logic [ACC_W-1:0]     sum,
    output logic [NUM_CORDS-1:0] lane_ovf
);

    acc_vec_t  acc_v;
    acc_vec_t  ext_v;
    acc_vec_t  sum_v;
    cord_vec_t pt_v;

    assign acc_v = acc;
    assign pt_v  = point;
    assign sum   = sum_v;

    // Overflow when both operands share a sign and the result's sign differs.
    always_comb begin
        ext_v    = '0;
        sum_v    = '0;
        lane_ovf = '0;
        for (int k = 0; k < int'(NUM_CORDS); k++) begin
            ext_v[k]    = {{(ACC_CORD_W-CORD_W){pt_v[k][CORD_W-1]}}, pt_v[k]};
            sum_v[k]    = acc_v[k] + ext_v[k];
            lane_ovf[k] = (acc_v[k][ACC_CORD_W-1] == ext_v[k][ACC_CORD_W-1]) &&
                          (sum_v[k][ACC_CORD_W-1] != acc_v[k][ACC_CORD_W-1]);
        end
    end

endmodule

// File: rtl/centroid_accumulator.sv
// Per-centroid running sums and point counts; on flush, presents each entry over
// valid/ready to the divider and clears it once consumed.
module centroid_accumulator
    import kmeans_pkg::*;
#(
    parameter int unsigned centroid_num = NUM_CENT
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            point_valid,
    output logic                            point_ready,
    input  logic [DATA_W-1:0]               point_data,
    input  logic [$clog2(centroid_num)-1:0] point_idx,
    input  logic                            flush,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(centroid_num)-1:0] out_idx,
    output logic [ACC_W-1:0]                accumulator,
    output logic [CNT_W-1:0]                counter,
    output logic                            out_overflow,
    output logic                            drain_done
);

    localparam int unsigned IW   = $clog2(centroid_num);
    localparam int unsigned LAST = centroid_num - 1;

    state_t state_q, state_d;

    acc_vec_t                sum_q [centroid_num];
    logic [CNT_W-1:0]        cnt_q [centroid_num];
    logic [centroid_num-1:0] ovf_q;
    logic [IW-1:0]           drain_idx_q;

    logic                 accept;
    logic                 take;
    logic                 last;
    logic [ACC_W-1:0]     sel_sum;
    logic [CNT_W-1:0]     sel_cnt;
    logic                 sel_ovf;
    logic [ACC_W-1:0]     add_sum;
    logic [NUM_CORDS-1:0] add_ovf;
    logic                 cnt_full;
    logic [ACC_W-1:0]     upd_sum;
    logic [CNT_W-1:0]     upd_cnt;
    logic                 upd_ovf;

    logic                 load;
    logic [IW-1:0]        load_idx;
    logic                 bypass;
    logic [ACC_W-1:0]     load_sum;
    logic [CNT_W-1:0]     load_cnt;
    logic                 load_ovf;

    assign out_idx = drain_idx_q;

    // Single shared adder operates on whichever entry the incoming point targets.
    assign sel_sum = sum_q[point_idx];
    assign sel_cnt = cnt_q[point_idx];
    assign sel_ovf = ovf_q[point_idx];

    acc_lane_adder u_adder (
        .acc      (sel_sum),
        .point    (point_data),
        .sum      (add_sum),
        .lane_ovf (add_ovf)
    );

    // A saturated counter drops the point entirely but still marks the entry.
    always_comb begin
        cnt_full = &sel_cnt;
        upd_sum  = cnt_full ? sel_sum : add_sum;
        upd_cnt  = cnt_full ? sel_cnt : sel_cnt + CNT_W'(1);
        upd_ovf  = sel_ovf | cnt_full | (|add_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        take    = 1'b0;
        last    = 1'b0;
        case (state_q)
            ACCUM: begin
                accept = point_valid && point_ready;
                if (flush) state_d = DRAIN;
            end
            DRAIN: begin
                take = out_valid && out_ready;
                if (take && (drain_idx_q == IW'(LAST))) begin
                    last    = 1'b1;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // Next entry to present; a point landing on that entry in the flush cycle is forwarded.
    always_comb begin
        load     = 1'b0;
        load_idx = '0;
        if (state_q == ACCUM && flush) begin
            load = 1'b1;
        end else if (take && !last) begin
            load     = 1'b1;
            load_idx = drain_idx_q + IW'(1);
        end
        bypass   = accept && (point_idx == load_idx);
        load_sum = bypass ? upd_sum : sum_q[load_idx];
        load_cnt = bypass ? upd_cnt : cnt_q[load_idx];
        load_ovf = bypass ? upd_ovf : ovf_q[load_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(centroid_num); i++) begin
                sum_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else if (accept) begin
            sum_q[point_idx] <= upd_sum;
            cnt_q[point_idx] <= upd_cnt;
            ovf_q[point_idx] <= upd_ovf;
        end else if (take) begin
            sum_q[drain_idx_q] <= '0;
            cnt_q[drain_idx_q] <= '0;
            ovf_q[drain_idx_q] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_idx_q  <= '0;
            point_ready  <= 1'b0;
            drain_done   <= 1'b0;
            out_valid    <= 1'b0;
            accumulator  <= '0;
            counter      <= '0;
            out_overflow <= 1'b0;
        end else begin
            point_ready <= (state_d == ACCUM);
            drain_done  <= last;
            if (take) drain_idx_q <= last ? '0 : drain_idx_q + IW'(1);
            if (load) begin
                out_valid    <= 1'b1;
                accumulator  <= load_sum;
                counter      <= load_cnt;
                out_overflow <= load_ovf;
            end else if (last) begin
                out_valid    <= 1'b0;
                accumulator  <= '0;
                counter      <= '0;
                out_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_centroid_accumulator.sv
// Directed bench for centroid_accumulator: accumulate, drain with/without backpressure,
// counter saturation, lane wrap and reset during drain.
module tb_centroid_accumulator;
    import kmeans_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              point_valid;
    logic              point_ready;
    logic [DATA_W-1:0] point_data;
    logic [IDX_W-1:0]  point_idx;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_idx;
    logic [ACC_W-1:0]  accumulator;
    logic [CNT_W-1:0]  counter;
    logic              out_overflow;
    logic              drain_done;

    int total;
    int bad;
    bit poke;

    logic [ACC_W-1:0] exp_acc [NUM_CENT];
    int               exp_cnt [NUM_CENT];
    logic             exp_ovf [NUM_CENT];

    centroid_accumulator #(.centroid_num(NUM_CENT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .point_valid  (point_valid),
        .point_ready  (point_ready),
        .point_data   (point_data),
        .point_idx    (point_idx),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_idx      (out_idx),
        .accumulator  (accumulator),
        .counter      (counter),
        .out_overflow (out_overflow),
        .drain_done   (drain_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] mk_point(input int v);
        cord_vec_t p;
        for (int k = 0; k < int'(NUM_CORDS); k++) p[k] = CORD_W'(v);
        return p;
    endfunction

    function automatic logic [ACC_W-1:0] mk_acc(input int v);
        acc_vec_t a;
        for (int k = 0; k < int'(NUM_CORDS); k++) a[k] = ACC_CORD_W'(v);
        return a;
    endfunction

    task automatic clear_exp();
        for (int i = 0; i < int'(NUM_CENT); i++) begin
            exp_acc[i] = '0;
            exp_cnt[i] = 0;
            exp_ovf[i] = 1'b0;
        end
    endtask

    task automatic send(input int idx, input logic [DATA_W-1:0] data, input int n);
        point_valid = 1'b1;
        point_idx   = IDX_W'(idx);
        point_data  = data;
        for (int j = 0; j < n; j++) tick();
        point_valid = 1'b0;
    endtask

    // Flush, optionally hold out_ready low, then walk all entries against exp_*.
    task automatic drain_all(input int hold);
        flush     = 1'b1;
        out_ready = 1'b0;
        tick();
        flush       = 1'b0;
        point_valid = 1'b0;
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_idx", out_idx, 0);
            chk("hold_acc", accumulator, exp_acc[0]);
            chk("hold_cnt", counter, exp_cnt[0]);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < int'(NUM_CENT); i++) begin
            if (poke) begin
                point_valid = (i < int'(NUM_CENT) - 1);
                point_idx   = IDX_W'(2);
                point_data  = mk_point(9);
            end
            chk($sformatf("valid[%0d]", i), out_valid, 1);
            chk($sformatf("idx[%0d]", i), out_idx, i);
            chk($sformatf("acc[%0d]", i), accumulator, exp_acc[i]);
            chk($sformatf("cnt[%0d]", i), counter, exp_cnt[i]);
            chk($sformatf("ovf[%0d]", i), out_overflow, exp_ovf[i]);
            chk($sformatf("pready_drain[%0d]", i), point_ready, 0);
            chk($sformatf("done_early[%0d]", i), drain_done, 0);
            tick();
        end
        point_valid = 1'b0;
        out_ready   = 1'b0;
        poke        = 1'b0;
        chk("done_pulse", drain_done, 1);
        chk("done_valid", out_valid, 0);
        chk("done_pready", point_ready, 1);
        tick();
        chk("done_low", drain_done, 0);
        clear_exp();
    endtask

    initial begin
        cord_vec_t mixed;
        acc_vec_t  mixed_acc;

        total       = 0;
        bad         = 0;
        poke        = 1'b0;
        rst_n       = 1'b0;
        point_valid = 1'b0;
        point_data  = '0;
        point_idx   = '0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        clear_exp();

        // Reset and idle
        tick();
        tick();
        chk("rst_pready", point_ready, 0);
        chk("rst_valid", out_valid, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_pready", point_ready, 1);
        chk("idle_valid", out_valid, 0);
        chk("idle_idx", out_idx, 0);
        chk("idle_acc", accumulator, 0);
        chk("idle_cnt", counter, 0);
        chk("idle_ovf", out_overflow, 0);
        chk("idle_done", drain_done, 0);
        drain_all(0);

        // Back-to-back points to centroid 3, plus a per-lane mixed-sign point to centroid 6
        point_valid = 1'b1;
        point_idx   = IDX_W'(3);
        point_data  = mk_point(100);
        tick();
        chk("b2b_pready", point_ready, 1);
        point_data = mk_point(-30);
        tick();
        for (int k = 0; k < int'(NUM_CORDS); k++) begin
            mixed[k]     = CORD_W'(k - 3);
            mixed_acc[k] = ACC_CORD_W'(k - 3);
        end
        send(6, mixed, 1);
        exp_acc[3] = mk_acc(70);
        exp_cnt[3] = 2;
        exp_acc[6] = mixed_acc;
        exp_cnt[6] = 1;
        drain_all(0);

        // Backpressure on entry 0
        send(0, mk_point(7), 1);
        exp_acc[0] = mk_acc(7);
        exp_cnt[0] = 1;
        drain_all(5);

        // Point coincident with flush is included; points offered in DRAIN are refused
        point_valid = 1'b1;
        point_idx   = IDX_W'(7);
        point_data  = mk_point(5);
        exp_acc[7]  = mk_acc(5);
        exp_cnt[7]  = 1;
        poke        = 1'b1;
        drain_all(0);
        drain_all(0);

        // Counter saturation boundary, then drop of one extra point
        send(0, mk_point(1), 1023);
        exp_acc[0] = mk_acc(1023);
        exp_cnt[0] = 1023;
        drain_all(0);
        send(0, mk_point(1), 1024);
        exp_acc[0] = mk_acc(1023);
        exp_cnt[0] = 1023;
        exp_ovf[0] = 1'b1;
        drain_all(0);
        drain_all(0);

        // Lane wrap: 513 x -4096 passes -2^21 and wraps to 0x1FF000
        send(5, mk_point(-4096), 513);
        exp_acc[5] = mk_acc(32'h1FF000);
        exp_cnt[5] = 513;
        exp_ovf[5] = 1'b1;
        drain_all(0);

        // Reset while entry 4 is presented
        send(4, mk_point(11), 1);
        send(1, mk_point(3), 1);
        flush     = 1'b1;
        out_ready = 1'b0;
        tick();
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        out_ready = 1'b0;
        chk("pre_rst_idx", out_idx, 4);
        chk("pre_rst_acc", accumulator, mk_acc(11));
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_pready", point_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_pready", point_ready, 1);
        clear_exp();
        drain_all(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
